fetch_stage: RTL and testbench

Instruction-fetch stage and IF/DE pipeline register of the debuggable RV32I core. It owns the program counter and drives the combinational instruction memory. It applies the hazard unit's `stall` and `flush` (branch-taken) controls to the decode-stage register. It also implements the external debugger's halt / resume / single-step / PC-write control through a small state machine that drains the pipeline before reporting halted.

---
 rtl/fetch_stage.sv | 134 +++++++++++++
 tb/tb_fetch_stage.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/DE pipeline register and debug halt/step control.
// The debug FSM drains DE..WB with bubbles before reporting halted.
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN     = 32'h0000_0013,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_de,
  output logic [31:0] ir_de,
  input  logic        dbg_halt_req,
  input  logic        dbg_resume_req,
  input  logic        dbg_step_req,
  input  logic        dbg_pc_wr,
  input  logic [31:0] dbg_pc_wdata,
  output logic        dbg_halted
);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_HALTED,
    S_STEP
  } state_e;

  localparam logic [2:0] CNT_LOAD = 3'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pcde_q, pcde_d;
  logic        fetch_en;
  logic        advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      pcde_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      pcde_q  <= pcde_d;
    end
  end

  // A flush moves the pipeline even when stall is also raised.
  assign advance = flush | ~stall;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fetch_en = 1'b0;

    case (state_q)
      S_RUN: begin
        fetch_en = ~dbg_halt_req;
        if (dbg_halt_req) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      S_DRAIN: begin
        if (advance) begin
          if (cnt_q == 3'd0) begin
            state_d = S_HALTED;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      S_HALTED: begin
        if (dbg_resume_req) begin
          state_d = S_RUN;
        end else if (dbg_step_req) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        fetch_en = 1'b1;
        if (!stall && !flush) begin
          state_d = S_DRAIN;
          cnt_d   = CNT_LOAD;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    pcde_d = pcde_q;

    if (state_q == S_HALTED) begin
      // Hazard controls are ignored while halted; only the debugger moves the PC.
      ir_d   = NOP_INSN;
      pcde_d = '0;
      if (dbg_pc_wr) begin
        pc_d = {dbg_pc_wdata[31:2], 2'b00};
      end
    end else if (flush) begin
      pc_d   = br_target;
      ir_d   = NOP_INSN;
      pcde_d = '0;
    end else if (stall) begin
      pc_d   = pc_q;
    end else if (fetch_en) begin
      pcde_d = pc_q;
      ir_d   = imem_rdata;
      pc_d   = pc_q + 32'd4;
    end else begin
      ir_d   = NOP_INSN;
      pcde_d = '0;
    end
  end

  assign imem_addr  = pc_q;
  assign pc_de      = pcde_q;
  assign ir_de      = ir_q;
  assign dbg_halted = (state_q == S_HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random traffic,
// compared cycle by cycle against a behavioural model of the fetch/debug rules.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          DC  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic [31:0] br_target;
  logic [31:0] imem_addr, imem_rdata, pc_de, ir_de;
  logic        dbg_halt_req, dbg_resume_req, dbg_step_req, dbg_pc_wr;
  logic [31:0] dbg_pc_wdata;
  logic        dbg_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ a ^ 32'h0BAD_0000;
  endfunction

  assign imem_rdata = memf(imem_addr);

  fetch_stage #(
    .RESET_PC(RPC),
    .NOP_INSN(NOP),
    .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .br_target(br_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc_de(pc_de), .ir_de(ir_de),
    .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
    .dbg_step_req(dbg_step_req), .dbg_pc_wr(dbg_pc_wr),
    .dbg_pc_wdata(dbg_pc_wdata), .dbg_halted(dbg_halted)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pcde;
    logic [31:0] ir;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] m_pc, m_ir, m_pcde;
  bit          m_halted;
  bit          m_step;   // step granted, instruction not yet taken
  int          m_drain;  // advancing edges left until halted, -1 when not draining

  task automatic model_reset();
    m_pc = RPC; m_ir = NOP; m_pcde = '0;
    m_halted = 1'b0; m_step = 1'b0; m_drain = -1;
  endtask

  task automatic push_exp();
    exp_q.push_back(exp_t'{addr: m_pc, pcde: m_pcde, ir: m_ir, halted: m_halted});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("pc_de", pc_de, e.pcde);
        chk("ir_de", ir_de, e.ir);
        chk("dbg_halted", {31'b0, dbg_halted}, {31'b0, e.halted});
      end
    end
  end

  task automatic cyc(input bit st, input bit fl, input logic [31:0] tgt, input bit hr,
                     input bit rr, input bit sr, input bit pw, input logic [31:0] wd);
    bit running;
    push_exp();
    stall = st; flush = fl; br_target = tgt; dbg_halt_req = hr;
    dbg_resume_req = rr; dbg_step_req = sr; dbg_pc_wr = pw; dbg_pc_wdata = wd;
    if (m_halted) begin
      if (pw) m_pc = {wd[31:2], 2'b00};
      m_ir = NOP; m_pcde = '0;
      if (rr) m_halted = 1'b0;
      else if (sr) begin m_halted = 1'b0; m_step = 1'b1; end
    end else begin
      running = (m_drain < 0) && !m_step;
      if (fl) begin
        m_pc = tgt; m_ir = NOP; m_pcde = '0;
      end else if (!st) begin
        if ((running && !hr) || m_step) begin
          m_pcde = m_pc; m_ir = memf(m_pc); m_pc = m_pc + 32'd4;
        end else begin
          m_ir = NOP; m_pcde = '0;
        end
      end
      if (running && hr) begin
        m_drain = DC;
      end else if (m_drain >= 0) begin
        if (fl || !st) begin
          m_drain--;
          if (m_drain == 0) begin m_halted = 1'b1; m_drain = -1; end
        end
      end else if (m_step && !st && !fl) begin
        m_step = 1'b0; m_drain = DC;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 0; flush = 0; br_target = '0; dbg_halt_req = 0; dbg_resume_req = 0;
    dbg_step_req = 0; dbg_pc_wr = 0; dbg_pc_wdata = '0;
    model_reset();
    push_exp();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic [31:0] tgt, wd;
    rst_n = 1'b0;
    stall = 0; flush = 0; br_target = '0; dbg_halt_req = 0; dbg_resume_req = 0;
    dbg_step_req = 0; dbg_pc_wr = 0; dbg_pc_wdata = '0;
    @(negedge clk);
    do_reset();

    idle(2);                                      // 0x100, 0x104 fetched
    cyc(1, 0, '0, 0, 0, 0, 0, '0);                // stall at 0x108
    cyc(1, 0, '0, 0, 0, 0, 0, '0);
    idle(2);
    cyc(1, 1, 32'h200, 0, 0, 0, 0, '0);           // flush beats stall
    idle(2);
    cyc(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, '0);     // PC wrap
    idle(2);
    cyc(0, 1, 32'h120, 0, 0, 0, 0, '0);
    cyc(0, 0, '0, 1, 0, 0, 0, '0);                // halt at 0x120
    idle(6);
    cyc(0, 0, '0, 0, 0, 0, 1, 32'h303);           // PC write while halted
    idle(1);
    cyc(0, 0, '0, 0, 0, 1, 0, '0);                // single step
    cyc(0, 0, '0, 1, 0, 0, 0, '0);                // halt during step is ignored
    idle(6);
    cyc(0, 0, '0, 0, 1, 1, 0, '0);                // resume and step together
    idle(3);
    cyc(0, 0, '0, 1, 0, 0, 0, '0);
    cyc(1, 0, '0, 0, 0, 0, 0, '0);                // stalled drain edge
    idle(1);
    do_reset();                                   // reset mid-drain
    idle(3);
    cyc(0, 0, '0, 1, 0, 0, 0, '0);
    idle(6);
    cyc(0, 0, '0, 0, 0, 1, 1, 32'h0000_0402);     // step with PC write same edge
    cyc(1, 0, '0, 0, 0, 0, 0, '0);                // stalled step edge
    idle(7);
    cyc(0, 0, '0, 0, 1, 0, 0, '0);

    for (int i = 0; i < 500; i++) begin
      tgt = $urandom & 32'hFFFF_FFFC;
      wd  = $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, tgt,
          $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, wd);
      if (i == 250) do_reset();
    end
    idle(2);

    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
